// File: rtl/flow_director_rss.sv
// RSS flow director: hash-indexed queue lookup, one register stage, credit-protected output FIFO.
// Optional FLOW_DIR_STATS_EN adds packet, stall and per-queue histogram counters.
module flow_director_rss #(
  parameter int unsigned META_W      = 512,
  parameter int unsigned NB_QUEUES   = 16,
  parameter int unsigned TABLE_DEPTH = 128,
  parameter int unsigned FIFO_DEPTH  = 8,
  localparam int unsigned QID_W      = $clog2(NB_QUEUES),
  localparam int unsigned IDX_W      = $clog2(TABLE_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [META_W-1:0] in_meta_data,
  input  logic [31:0]       in_meta_hash,
  input  logic              in_meta_valid,
  output logic              in_meta_ready,
  output logic [META_W-1:0] out_meta_data,
  output logic [QID_W-1:0]  out_meta_queue,
  output logic              out_meta_valid,
  input  logic              out_meta_ready,
  input  logic              cfg_wr_en,
  input  logic [IDX_W-1:0]  cfg_wr_addr,
  input  logic [QID_W-1:0]  cfg_wr_data
`ifdef FLOW_DIR_STATS_EN
  ,
  output logic [31:0]                 out_pkt_cnt,
  output logic [31:0]                 stall_cnt,
  output logic [NB_QUEUES-1:0][15:0]  q_hist_cnt
`endif
);

  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned ENTRY_W = META_W + QID_W;

  logic [QID_W-1:0]   table_q [TABLE_DEPTH];
  logic               s1_valid_q;
  logic [META_W-1:0]  s1_data_q;
  logic [QID_W-1:0]   s1_queue_q;
  logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W:0]     wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]     fifo_count;
  logic [PTR_W+1:0]   credit_used;
  logic [IDX_W-1:0]   lookup_idx;
  logic [ENTRY_W-1:0] head;
  logic               in_accept, out_pop, fifo_empty;
  logic               unused_hash_bits;

  assign lookup_idx       = in_meta_hash[IDX_W-1:0];
  assign unused_hash_bits = ^in_meta_hash[31:IDX_W];

  // Stage 1 is counted against the credit because it always pushes on the next edge.
  assign fifo_count    = wr_ptr_q - rd_ptr_q;
  assign credit_used   = {1'b0, fifo_count} + {{(PTR_W+1){1'b0}}, s1_valid_q};
  assign in_meta_ready = credit_used < (PTR_W+2)'(FIFO_DEPTH);
  assign in_accept     = in_meta_valid && in_meta_ready;

  assign fifo_empty     = (wr_ptr_q == rd_ptr_q);
  assign out_meta_valid = !fifo_empty;
  assign out_pop        = out_meta_valid && out_meta_ready;
  assign head           = mem_q[rd_ptr_q[PTR_W-1:0]];

  // Gating by valid gives zero outputs while empty, including during reset.
  always_comb begin
    out_meta_data  = '0;
    out_meta_queue = '0;
    if (out_meta_valid) begin
      out_meta_data  = head[ENTRY_W-1:QID_W];
      out_meta_queue = head[QID_W-1:0];
    end
  end

  // Lookup reads before the edge, so a same-cycle write to that entry returns the old value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(TABLE_DEPTH); i++) begin
        table_q[i] <= QID_W'(i & int'(NB_QUEUES - 1));
      end
    end else if (cfg_wr_en) begin
      table_q[cfg_wr_addr] <= cfg_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_queue_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      s1_valid_q <= in_accept;
      if (in_accept) begin
        s1_queue_q <= table_q[lookup_idx];
      end
      if (s1_valid_q) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (out_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  // Wide payload storage carries no reset; validity lives in the pointers and s1_valid_q.
  always_ff @(posedge clk) begin
    if (in_accept) begin
      s1_data_q <= in_meta_data;
    end
    if (s1_valid_q) begin
      mem_q[wr_ptr_q[PTR_W-1:0]] <= {s1_data_q, s1_queue_q};
    end
  end

`ifdef FLOW_DIR_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_pkt_cnt <= '0;
      stall_cnt   <= '0;
      q_hist_cnt  <= '0;
    end else begin
      if (out_pop) begin
        out_pkt_cnt <= out_pkt_cnt + 32'd1;
        if (q_hist_cnt[out_meta_queue] != 16'hFFFF) begin
          q_hist_cnt[out_meta_queue] <= q_hist_cnt[out_meta_queue] + 16'd1;
        end
      end
      if (in_meta_valid && !in_meta_ready) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_flow_director_rss.sv
// Directed self-checking bench for flow_director_rss with default parameters.
module tb_flow_director_rss;
  localparam int META_W = 512;
  localparam int QID_W  = 4;
  localparam int IDX_W  = 7;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [META_W-1:0] in_meta_data = '0;
  logic [31:0]       in_meta_hash = '0;
  logic              in_meta_valid = 1'b0;
  logic              in_meta_ready;
  logic [META_W-1:0] out_meta_data;
  logic [QID_W-1:0]  out_meta_queue;
  logic              out_meta_valid;
  logic              out_meta_ready = 1'b0;
  logic              cfg_wr_en = 1'b0;
  logic [IDX_W-1:0]  cfg_wr_addr = '0;
  logic [QID_W-1:0]  cfg_wr_data = '0;

  int checks = 0;
  int errors = 0;
  int n;
  logic acc;

  flow_director_rss dut (
    .clk            (clk),
    .rst            (rst),
    .in_meta_data   (in_meta_data),
    .in_meta_hash   (in_meta_hash),
    .in_meta_valid  (in_meta_valid),
    .in_meta_ready  (in_meta_ready),
    .out_meta_data  (out_meta_data),
    .out_meta_queue (out_meta_queue),
    .out_meta_valid (out_meta_valid),
    .out_meta_ready (out_meta_ready),
    .cfg_wr_en      (cfg_wr_en),
    .cfg_wr_addr    (cfg_wr_addr),
    .cfg_wr_data    (cfg_wr_data)
  );

  always #5 clk = ~clk;

  function automatic logic [META_W-1:0] mk(input int k);
    return {16{32'(k) ^ 32'h5A5A_0000}};
  endfunction

  task automatic chk(input string tag, input logic [META_W-1:0] obs,
                     input logic [META_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_check(input string tag, input int q, input int k);
    chk({tag, "_valid"}, META_W'(out_meta_valid), 1);
    chk({tag, "_queue"}, META_W'(out_meta_queue), META_W'(q));
    chk({tag, "_data"}, out_meta_data, mk(k));
    out_meta_ready = 1'b1;
    step();
    out_meta_ready = 1'b0;
  endtask

  initial begin
    // Reset state while asserted, then after release.
    #3;
    chk("rst_valid", META_W'(out_meta_valid), 0);
    chk("rst_queue", META_W'(out_meta_queue), 0);
    chk("rst_data", out_meta_data, 0);
    #9 rst = 1'b1;
    step();
    chk("rst_ready", META_W'(in_meta_ready), 1);
    chk("rst_empty", META_W'(out_meta_valid), 0);

    // Reset table pattern, streaming at full rate: word k is visible two edges after accept.
    out_meta_ready = 1'b1;
    for (int k = 0; k < 130; k++) begin
      in_meta_valid = (k < 128);
      in_meta_hash  = 32'(k);
      in_meta_data  = mk(k);
      chk("stream_ready", META_W'(in_meta_ready), 1);
      if (k >= 2) begin
        chk("stream_valid", META_W'(out_meta_valid), 1);
        chk("stream_queue", META_W'(out_meta_queue), META_W'((k - 2) & 15));
        chk("stream_data", out_meta_data, mk(k - 2));
      end else begin
        chk("stream_latency", META_W'(out_meta_valid), 0);
      end
      step();
    end
    in_meta_valid = 1'b0;
    chk("stream_drained", META_W'(out_meta_valid), 0);

    // Reprogram and same-cycle write/lookup collision.
    out_meta_ready = 1'b0;
    cfg_wr_en = 1'b1; cfg_wr_addr = 7'h05; cfg_wr_data = 4'd9;
    step();
    cfg_wr_en = 1'b0;
    in_meta_valid = 1'b1; in_meta_hash = 32'h1234_0085; in_meta_data = mk(1000);
    step();
    cfg_wr_en = 1'b1; cfg_wr_addr = 7'h06; cfg_wr_data = 4'd3;
    in_meta_hash = 32'h0000_0006; in_meta_data = mk(1001);
    step();
    cfg_wr_en = 1'b0;
    in_meta_data = mk(1002);
    step();
    in_meta_valid = 1'b0;
    step();
    pop_check("reprog", 9, 1000);
    pop_check("collide_old", 6, 1001);
    pop_check("collide_new", 3, 1002);
    chk("reprog_empty", META_W'(out_meta_valid), 0);

    // Backpressure: exactly FIFO_DEPTH words accepted, held stable, then drained in order.
    n = 0;
    repeat (16) begin
      in_meta_valid = 1'b1;
      in_meta_hash  = 32'h10 + 32'(n);
      in_meta_data  = mk(2000 + n);
      acc = in_meta_ready;
      step();
      if (acc) n++;
    end
    in_meta_valid = 1'b0;
    chk("bp_accepted", META_W'(n), 8);
    chk("bp_ready_low", META_W'(in_meta_ready), 0);
    step();
    step();
    chk("bp_hold_data", out_meta_data, mk(2000));
    chk("bp_hold_queue", META_W'(out_meta_queue), 0);
    for (int i = 0; i < 8; i++) begin
      pop_check("bp_drain", i, 2000 + i);
    end
    chk("bp_empty", META_W'(out_meta_valid), 0);
    chk("bp_ready_back", META_W'(in_meta_ready), 1);

    // Asynchronous reset with 5 buffered words; table must return to its reset pattern.
    cfg_wr_en = 1'b1; cfg_wr_addr = 7'h07; cfg_wr_data = 4'd12;
    step();
    cfg_wr_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_meta_valid = 1'b1;
      in_meta_hash  = 32'h20 + 32'(i);
      in_meta_data  = mk(3000 + i);
      step();
    end
    in_meta_valid = 1'b0;
    step();
    chk("pre_reset_valid", META_W'(out_meta_valid), 1);
    #3 rst = 1'b0;
    #1;
    chk("arst_valid", META_W'(out_meta_valid), 0);
    chk("arst_queue", META_W'(out_meta_queue), 0);
    chk("arst_data", out_meta_data, 0);
    #2 rst = 1'b1;
    step();
    chk("post_rst_ready", META_W'(in_meta_ready), 1);
    chk("post_rst_empty", META_W'(out_meta_valid), 0);
    in_meta_valid = 1'b1; in_meta_hash = 32'h05; in_meta_data = mk(4000);
    step();
    in_meta_hash = 32'h07; in_meta_data = mk(4001);
    step();
    in_meta_valid = 1'b0;
    step();
    pop_check("tbl_rst_5", 5, 4000);
    pop_check("tbl_rst_7", 7, 4001);
    chk("no_stale", META_W'(out_meta_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
